speck_key_sequencer: RTL
========================

SPECK_KEY_SEQUENCER -- requirements
Module: speck_key_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 32, number of round keys emitted per key (range 2..32).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  begin a schedule run for the value on key.
REQ-005 SHALL have port key  input  128  master key; sampled only on the cycle start is accepted.
REQ-006 SHALL have port busy  output  1  high from start acceptance through the done cycle.
REQ-007 SHALL have port done  output  1  one-cycle pulse after the last round key handshake.
REQ-008 SHALL have port rk_valid  output  1  round key is valid on rk_data.
REQ-009 SHALL have port rk_ready  input  1  consumer accepts rk_data.
REQ-010 SHALL have port rk_data  output  64  current round key.
REQ-011 SHALL have port rk_index  output  5  round index of rk_data, 0..NUM_ROUNDS-1.
REQ-012 SHALL have port ks_start  output  1  start pulse to the key-schedule unit.
REQ-013 SHALL have port ks_key  output  128  key word presented to the key-schedule unit.
REQ-014 SHALL have port ks_round_ctr  output  64  round constant presented to the key-schedule unit.
REQ-015 SHALL have port ks_finished  input  1  key-schedule finished flag; level, may stay high between runs.
REQ-016 SHALL have port ks_outKey  input  128  updated key word from the key-schedule unit.
REQ-017 SHALL have port ks_state  input  4  key-schedule state; 0 means idle.

Function
REQ-018 SHALL implement states IDLE, EMIT, KS_START, KS_WAIT, DONE.
REQ-019 IDLE: start=1 -> kreg<=key, idx<=0, busy<=1, next EMIT; start is ignored in every other state.
REQ-020 EMIT: rk_valid=1, rk_data=kreg[63:0], rk_index=idx; rk_data and rk_index SHALL hold stable while rk_valid=1 and rk_ready=0.
REQ-021 EMIT, handshake (rk_valid & rk_ready): idx=NUM_ROUNDS-1 -> DONE; otherwise -> KS_START.
REQ-022 KS_START: ks_start SHALL assert only when ks_state=0, for exactly one cycle, then -> KS_WAIT; with ks_state!=0 the block stays in KS_START with ks_start=0.
REQ-023 ks_key SHALL equal kreg, and ks_round_ctr SHALL equal zero-extended idx, from KS_START through KS_WAIT.
REQ-024 KS_WAIT SHALL complete only on a rising edge of ks_finished (registered previous value =0, current =1); a level-high flag left over from an earlier run SHALL NOT complete it.
REQ-025 KS_WAIT completion: kreg<=ks_outKey, idx<=idx+1, next EMIT.
REQ-026 DONE: done=1 for one cycle, busy=0 and -> IDLE on the next cycle; start in DONE is ignored.
REQ-027 Throughput: at most one round key per key-schedule run; first rk_valid SHALL appear on the cycle after start acceptance.
REQ-028 idx SHALL never exceed NUM_ROUNDS-1 and SHALL NOT wrap within a run.

Reset
REQ-029 rst=1 at any clock edge SHALL force IDLE, with busy=0, done=0, rk_valid=0, ks_start=0, rk_index=0, rk_data=0, ks_key=0, ks_round_ctr=0, and the ks_finished edge register=0.
REQ-030 Reset mid-run SHALL discard the run; the next run's first ks_start SHALL still wait for ks_state=0 (REQ-022).

Verification
REQ-031 Key 0x0f0e0d0c0b0a0908_0706050403020100, start, rk_ready=1 -> rk_index 0 with rk_data 0x0706050403020100 on the cycle after start; ks_key equals the key and ks_round_ctr=0 at the first ks_start.
REQ-032 Full run with a behavioural key-schedule model (finished stays high until its next start) -> 32 handshakes with indices 0..31, then exactly one done pulse and busy=0.
REQ-033 rk_ready held low for 5 cycles at index 3 -> rk_data and rk_index stable for those cycles and no ks_start issued.
REQ-034 ks_finished already high when KS_WAIT is entered -> no advance until the flag goes low and then high again.
REQ-035 ks_state=4 at KS_START for 3 cycles -> ks_start held low, then a single ks_start pulse on the first cycle ks_state=0.
REQ-036 rst asserted in KS_WAIT at index 10, then start with a new key -> idle outputs immediately after reset; the new run starts at index 0 with the new key.

Source files
------------

// File: rtl/speck_key_sequencer.sv
// ---------------------------------------------------------------------------------------------
// speck_key_sequencer
//
// Drives an external Speck key-schedule unit once per round. It streams NUM_ROUNDS round keys,
// taken from the low 64 bits of the running key word, over a valid/ready interface. The first
// round key is the master key itself. Each further round key comes from one key-schedule run.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   start / key   begin a run; key is captured only on the accepting cycle
//   busy          high from start acceptance through the done cycle
//   done          one-cycle pulse after the last round-key handshake
//   rk_valid/rk_ready/rk_data/rk_index
//                 round-key stream; data and index hold while stalled
//   ks_start      one-cycle start pulse to the key-schedule unit (only while ks_state == 0)
//   ks_key        key word presented to the key-schedule unit
//   ks_round_ctr  zero-extended round index presented to the key-schedule unit
//   ks_finished   key-schedule finished level; only its rising edge is used
//   ks_outKey     updated key word returned by the key-schedule unit
//   ks_state      key-schedule state, 0 = idle
// ---------------------------------------------------------------------------------------------
module speck_key_sequencer #(
   parameter int unsigned NUM_ROUNDS = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [63:0]  rk_data,
   output logic [4:0]   rk_index,
   output logic         ks_start,
   output logic [127:0] ks_key,
   output logic [63:0]  ks_round_ctr,
   input  logic         ks_finished,
   input  logic [127:0] ks_outKey,
   input  logic [3:0]   ks_state
);

   localparam logic [4:0] LastIdx = 5'(NUM_ROUNDS - 1);

   typedef enum logic [2:0] {
      StIdle,
      StEmit,
      StKsStart,
      StKsWait,
      StDone
   } state_e;

   state_e         state_q, state_d;
   logic [127:0]   kreg_q, kreg_d;
   logic [4:0]     idx_q, idx_d;
   logic           fin_q;
   logic           fin_rise;

   // The finished flag can be left high by an earlier run. Only a fresh 0->1 transition
   // counts as completion.
   assign fin_rise = ks_finished & ~fin_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         kreg_q  <= '0;
         idx_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         kreg_q  <= kreg_d;
         idx_q   <= idx_d;
         fin_q   <= ks_finished;
      end
   end

   always_comb begin
      state_d  = state_q;
      kreg_d   = kreg_q;
      idx_d    = idx_q;
      busy     = (state_q != StIdle);
      done     = 1'b0;
      rk_valid = 1'b0;
      ks_start = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) begin
               kreg_d  = key;
               idx_d   = '0;
               state_d = StEmit;
            end
         end
         StEmit: begin
            rk_valid = 1'b1;
            if (rk_ready) begin
               state_d = (idx_q == LastIdx) ? StDone : StKsStart;
            end
         end
         StKsStart: begin
            // Hold off until the key-schedule unit is idle, then pulse once.
            if (ks_state == 4'd0) begin
               ks_start = 1'b1;
               state_d  = StKsWait;
            end
         end
         StKsWait: begin
            if (fin_rise) begin
               kreg_d  = ks_outKey;
               idx_d   = idx_q + 5'd1;
               state_d = StEmit;
            end
         end
         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // kreg and idx only change on a handshake or a key-schedule completion, so they are
   // stable during stalls and across KS_START/KS_WAIT.
   assign rk_data      = kreg_q[63:0];
   assign rk_index     = idx_q;
   assign ks_key       = kreg_q;
   assign ks_round_ctr = {59'd0, idx_q};

endmodule
